// File: rtl/icache_pkg.sv
// Shared definitions for the parametrised I-cache: FSM encoding, width helper
// and address-field slicing used by the top level and the way arrays.
package icache_pkg;

  typedef enum logic [6:0] {
    S_IDLE     = 7'b000_0001,
    S_LOOKUP   = 7'b000_0010,
    S_MISS_REQ = 7'b000_0100,
    S_RECV     = 7'b000_1000,
    S_REFILL   = 7'b001_0000,
    S_RESP     = 7'b010_0000,
    S_INV      = 7'b100_0000
  } state_e;

  function automatic int clog2(input int unsigned v);
    int          r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int offset_w,
                                             input int index_w);
    return (addr >> offset_w) & ((32'd1 << index_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int offset_w,
                                           input int index_w);
    return addr >> (offset_w + index_w);
  endfunction

  // Word position inside the line; the two byte-offset bits are skipped.
  function automatic logic [31:0] addr_word(input logic [31:0] addr, input int offset_w);
    return (addr >> 2) & ((32'd1 << (offset_w - 2)) - 32'd1);
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] addr, input int offset_w);
    return addr & ~((32'd1 << offset_w) - 32'd1);
  endfunction

endpackage

// File: rtl/icache_way_array.sv
// One cache way: tag and line storage, NUM_SETS deep, combinational read and
// synchronous whole-line write. Valid bits live in the top level.
module icache_way_array
  import icache_pkg::*;
#(
  parameter int NUM_SETS   = 8,
  parameter int LINE_WORDS = 8,
  parameter int TAG_W      = 24
) (
  input  logic                               clk,
  input  logic                               we_i,
  input  logic [clog2(NUM_SETS)-1:0]         wr_idx_i,
  input  logic [TAG_W-1:0]                   wr_tag_i,
  input  logic [LINE_WORDS*32-1:0]           wr_line_i,
  input  logic [clog2(NUM_SETS)-1:0]         rd_idx_i,
  output logic [TAG_W-1:0]                   rd_tag_o,
  output logic [LINE_WORDS*32-1:0]           rd_line_o
);

  logic [TAG_W-1:0]         tag_mem  [NUM_SETS];
  logic [LINE_WORDS*32-1:0] data_mem [NUM_SETS];

  // NOTE: storage arrays carry no reset; the valid bits guard every read,
  // so resetting them would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_mem[wr_idx_i]  <= wr_tag_i;
      data_mem[wr_idx_i] <= wr_line_i;
    end
  end

  assign rd_tag_o  = tag_mem[rd_idx_i];
  assign rd_line_o = data_mem[rd_idx_i];

endmodule

// File: rtl/icache_param.sv
// Blocking set-associative instruction cache with age-based LRU, single-cycle
// invalidate-all and hit/miss counters. One outstanding request at a time.
module icache_param
  import icache_pkg::*;
#(
  parameter int NUM_SETS   = 8,
  parameter int NUM_WAYS   = 4,
  parameter int LINE_WORDS = 8,
  parameter int AGE_W      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        from_cpu_inst_req_valid,
  input  logic [31:0] from_cpu_inst_req_addr,
  output logic        to_cpu_inst_req_ready,
  output logic        to_cpu_cache_rsp_valid,
  output logic [31:0] to_cpu_cache_rsp_data,
  input  logic        from_cpu_cache_rsp_ready,
  input  logic        from_cpu_inv_req_valid,
  output logic        to_cpu_inv_req_ready,
  output logic        to_mem_rd_req_valid,
  output logic [31:0] to_mem_rd_req_addr,
  input  logic        from_mem_rd_req_ready,
  input  logic        from_mem_rd_rsp_valid,
  input  logic [31:0] from_mem_rd_rsp_data,
  input  logic        from_mem_rd_rsp_last,
  output logic        to_mem_rd_rsp_ready,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int OFFSET_W = clog2(LINE_WORDS) + 2;
  localparam int INDEX_W  = clog2(NUM_SETS);
  localparam int TAG_W    = 32 - INDEX_W - OFFSET_W;
  localparam int WAY_W    = clog2(NUM_WAYS);
  localparam int WORD_W   = clog2(LINE_WORDS);
  localparam int CNT_W    = WORD_W + 1;

  state_e                state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]   valid_d [NUM_SETS];
  logic [AGE_W-1:0]      age_q   [NUM_SETS][NUM_WAYS];
  logic [AGE_W-1:0]      age_d   [NUM_SETS][NUM_WAYS];
  logic [31:0]           hit_cnt_q, hit_cnt_d;
  logic [31:0]           miss_cnt_q, miss_cnt_d;
  logic [31:0]           rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [WAY_W-1:0]      way_q, way_d;
  logic [31:0]           line_buf_q [LINE_WORDS];
  logic [31:0]           line_buf_d [LINE_WORDS];

  logic [INDEX_W-1:0]           idx;
  logic [TAG_W-1:0]             tag;
  logic [WORD_W-1:0]            word;
  logic [TAG_W-1:0]             rd_tag  [NUM_WAYS];
  logic [LINE_WORDS*32-1:0]     rd_line [NUM_WAYS];
  logic [LINE_WORDS*32-1:0]     fill_line;
  logic [NUM_WAYS-1:0]          way_we;
  logic                         hit;
  logic [WAY_W-1:0]             hit_way;
  logic [31:0]                  hit_word;
  logic                         have_invalid;
  logic [WAY_W-1:0]             victim;
  logic [AGE_W-1:0]             best_age;

  assign idx  = INDEX_W'(addr_index(addr_q, OFFSET_W, INDEX_W));
  assign tag  = TAG_W'(addr_tag(addr_q, OFFSET_W, INDEX_W));
  assign word = WORD_W'(addr_word(addr_q, OFFSET_W));

  for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
    icache_way_array #(
      .NUM_SETS   (NUM_SETS),
      .LINE_WORDS (LINE_WORDS),
      .TAG_W      (TAG_W)
    ) u_way (
      .clk       (clk),
      .we_i      (way_we[g]),
      .wr_idx_i  (idx),
      .wr_tag_i  (tag),
      .wr_line_i (fill_line),
      .rd_idx_i  (idx),
      .rd_tag_o  (rd_tag[g]),
      .rd_line_o (rd_line[g])
    );
  end

  // Hit detection and victim choice: lowest invalid way, else oldest way with
  // ties resolved towards the lowest index.
  always_comb begin
    hit          = 1'b0;
    hit_way      = '0;
    have_invalid = 1'b0;
    victim       = '0;
    best_age     = '0;
    fill_line    = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && rd_tag[w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx][w]) begin
        have_invalid = 1'b1;
        victim       = WAY_W'(w);
      end
    end
    if (!have_invalid) begin
      best_age = age_q[idx][0];
      for (int w = 1; w < NUM_WAYS; w++) begin
        if (age_q[idx][w] > best_age) begin
          best_age = age_q[idx][w];
          victim   = WAY_W'(w);
        end
      end
    end
    hit_word = rd_line[hit_way][32*int'(word) +: 32];
    for (int i = 0; i < LINE_WORDS; i++) fill_line[32*i +: 32] = line_buf_q[i];
  end

  // NOTE: every variable gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    age_d      = age_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    rsp_data_d = rsp_data_q;
    beat_cnt_d = beat_cnt_q;
    way_d      = way_q;
    line_buf_d = line_buf_q;
    way_we     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (from_cpu_inv_req_valid) begin
          state_d = S_INV;
        end else if (from_cpu_inst_req_valid) begin
          addr_d  = from_cpu_inst_req_addr;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          hit_cnt_d  = hit_cnt_q + 32'd1;
          way_d      = hit_way;
          rsp_data_d = hit_word;
          state_d    = S_RESP;
        end else begin
          miss_cnt_d = miss_cnt_q + 32'd1;
          way_d      = victim;
          state_d    = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        if (from_mem_rd_req_ready) begin
          beat_cnt_d = '0;
          state_d    = S_RECV;
        end
      end
      S_RECV: begin
        if (from_mem_rd_rsp_valid) begin
          // Surplus beats are dropped; the counter parks at LINE_WORDS.
          if (beat_cnt_q < CNT_W'(LINE_WORDS)) begin
            line_buf_d[beat_cnt_q[WORD_W-1:0]] = from_mem_rd_rsp_data;
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
          if (from_mem_rd_rsp_last) state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        way_we[way_q]       = 1'b1;
        valid_d[idx][way_q] = 1'b1;
        rsp_data_d          = line_buf_q[word];
        state_d             = S_RESP;
      end
      S_RESP: begin
        if (from_cpu_cache_rsp_ready) begin
          for (int w = 0; w < NUM_WAYS; w++) begin
            if (w == int'(way_q))            age_d[idx][w] = '0;
            else if (age_q[idx][w] != '1)    age_d[idx][w] = age_q[idx][w] + 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      S_INV: begin
        for (int s = 0; s < NUM_SETS; s++) begin
          valid_d[s] = '0;
          for (int w = 0; w < NUM_WAYS; w++) age_d[s][w] = '0;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      rsp_data_q <= '0;
      beat_cnt_q <= '0;
      way_q      <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= '0;
      end
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      rsp_data_q <= rsp_data_d;
      beat_cnt_q <= beat_cnt_d;
      way_q      <= way_d;
      valid_q    <= valid_d;
      age_q      <= age_d;
    end
  end

  always_ff @(posedge clk) begin
    line_buf_q <= line_buf_d;
  end

  assign to_cpu_inst_req_ready  = (state_q == S_IDLE);
  assign to_cpu_inv_req_ready   = (state_q == S_IDLE);
  assign to_cpu_cache_rsp_valid = (state_q == S_RESP);
  assign to_cpu_cache_rsp_data  = rsp_data_q;
  assign to_mem_rd_req_valid    = (state_q == S_MISS_REQ);
  assign to_mem_rd_req_addr     = (state_q == S_MISS_REQ) ? line_base(addr_q, OFFSET_W) : '0;
  assign to_mem_rd_rsp_ready    = (state_q == S_RECV);
  assign hit_cnt                = hit_cnt_q;
  assign miss_cnt               = miss_cnt_q;

endmodule
